// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard/stall scheduler.
// - Tuse/Tnew encodings, register-zero constant, MDU latency defaults.
// - md_state_e names the two MDU sequencer states held by the busy counter.
package pipe_pkg;

    // Source operand not read by the instruction in D.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Architectural zero register: never a real producer.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Multi-cycle MDU latencies (busy cycles after issue in E).
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int CNT_W       = 4;

    // Tnew per instruction class (cycles until the result can be forwarded).
    localparam logic [1:0] TNEW_READY = 2'd0;  // already forwardable / no result
    localparam logic [1:0] TNEW_ALU   = 2'd1;  // ALU result available out of E
    localparam logic [1:0] TNEW_LOAD  = 2'd2;  // load data available out of M

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_counter.sv
// MDU busy sequencer.
// - Loads the busy counter on a mult/div issue while idle, then counts down.
// - A second issue while busy does not reload; it raises the sticky error flag.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   md_start        : mult/div issue in E this cycle
//   md_div          : 1 = div class, 0 = mult class
//   busy_cnt        : remaining busy cycles (0 = idle)
//   md_err          : sticky overlap error, cleared only by reset
module mdu_busy_counter
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_CYCLES,
    parameter int DIV_LAT  = DIV_CYCLES,
    parameter int CW       = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          md_start,
    input  logic          md_div,
    output logic [CW-1:0] busy_cnt,
    output logic          md_err
);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT);

    logic [CW-1:0] busy_cnt_d, busy_cnt_q;
    logic          md_err_d, md_err_q;
    md_state_e     md_state_s;

    // Next-state: load when idle, decrement when busy, flag overlapping issues.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        md_err_d   = md_err_q;
        md_state_s = (busy_cnt_q != {CW{1'b0}}) ? MD_BUSY : MD_IDLE;
        case (md_state_s)
            MD_IDLE: begin
                if (md_start) begin
                    busy_cnt_d = md_div ? DIV_LOAD : MULT_LOAD;
                end else begin
                    busy_cnt_d = busy_cnt_q;
                end
            end
            MD_BUSY: begin
                busy_cnt_d = busy_cnt_q - CW'(1);
                if (md_start) begin
                    md_err_d = 1'b1;
                end else begin
                    md_err_d = md_err_q;
                end
            end
            default: begin
                busy_cnt_d = {CW{1'b0}};
                md_err_d   = md_err_q;
            end
        endcase
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_q <= {CW{1'b0}};
            md_err_q   <= 1'b0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            md_err_q   <= md_err_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign md_err   = md_err_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// - Tuse/Tnew data-hazard compare of D sources against E and M destinations.
// - Multi-cycle MDU busy sequencing; md instructions in D wait for the MDU.
// - One stall condition drives PC hold, IF_ID hold and ID_EX bubble together.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   D_rs/D_rt, D_tuse_rs/rt   : D sources and their Tuse (3 = unused)
//   D_is_md                   : D instruction uses the MDU / HI/LO
//   E_wa/E_tnew, M_wa/M_tnew  : producers in E and M with their Tnew
//   E_md_start, E_md_div      : mult/div issue in E and its class
//   stall_F, stall_D, flush_E : hold PC, hold IF_ID, bubble ID_EX
//   md_busy, md_err           : MDU occupied, sticky overlap error
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_CYCLES,
    parameter int DIV_LAT  = DIV_CYCLES,
    parameter int CW       = CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_is_md,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_div,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_E,
    output logic       md_busy,
    output logic       md_err
);

    logic [CW-1:0] busy_cnt_s;
    logic          md_busy_s;
    logic          hz_e_s, hz_m_s, md_hz_s, stall_s;

    // A source hazards when it reads a live producer sooner than it is ready.
    function automatic logic src_hz(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] wa, input logic [1:0] tnew);
        return (src == wa) && (wa != REG_ZERO) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

    mdu_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CW       (CW)
    ) u_mdu_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .md_start (E_md_start),
        .md_div   (E_md_div),
        .busy_cnt (busy_cnt_s),
        .md_err   (md_err)
    );

    // Combinational hazard detection and stall fan-out, forced quiet in reset.
    always_comb begin
        hz_e_s    = src_hz(D_rs, D_tuse_rs, E_wa, E_tnew) | src_hz(D_rt, D_tuse_rt, E_wa, E_tnew);
        hz_m_s    = src_hz(D_rs, D_tuse_rs, M_wa, M_tnew) | src_hz(D_rt, D_tuse_rt, M_wa, M_tnew);
        // An issue this cycle counts as busy: the counter loads on this edge.
        md_busy_s = E_md_start | (busy_cnt_s != {CW{1'b0}});
        md_hz_s   = D_is_md & md_busy_s;
        stall_s   = hz_e_s | hz_m_s | md_hz_s;
        if (reset) begin
            stall_F = 1'b0;
            stall_D = 1'b0;
            flush_E = 1'b0;
            md_busy = 1'b0;
        end else begin
            stall_F = stall_s;
            stall_D = stall_s;
            flush_E = stall_s;
            md_busy = md_busy_s;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_div;
    logic       stall_F, stall_D, flush_E, md_busy, md_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model: remaining MDU busy cycles and sticky error.
    int m_rem = 0;
    bit m_err = 0;

    logic last_stall, last_busy, last_err;

    hazard_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall_F    (stall_F),
        .stall_D    (stall_D),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .md_err     (md_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 1'b0;
        E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_div = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven: check the
    // combinational outputs, then advance the model across the rising edge.
    task automatic cycle_check();
        bit         hz;
        bit         busy;
        logic [4:0] src;
        int         tu;
        if (reset) begin
            m_rem = 0;
            m_err = 0;
        end
        #1;
        hz = 0;
        for (int s = 0; s < 2; s++) begin
            src = (s == 1) ? D_rt : D_rs;
            tu  = (s == 1) ? int'(D_tuse_rt) : int'(D_tuse_rs);
            if (src != 5'd0 && tu != 3) begin
                if (src == E_wa && tu < int'(E_tnew)) hz = 1;
                if (src == M_wa && tu < int'(M_tnew)) hz = 1;
            end
        end
        busy = E_md_start || (m_rem > 0);
        if (D_is_md && busy) hz = 1;
        if (reset) begin
            hz   = 0;
            busy = 0;
        end
        check_eq("stall_F", {31'd0, stall_F}, {31'd0, hz});
        check_eq("stall_D", {31'd0, stall_D}, {31'd0, hz});
        check_eq("flush_E", {31'd0, flush_E}, {31'd0, hz});
        check_eq("md_busy", {31'd0, md_busy}, {31'd0, busy});
        check_eq("md_err",  {31'd0, md_err},  {31'd0, m_err});
        last_stall = stall_F;
        last_busy  = md_busy;
        last_err   = md_err;
        @(posedge clk);
        if (!reset) begin
            if (m_rem > 0) begin
                if (E_md_start) m_err = 1;
                m_rem--;
            end else if (E_md_start) begin
                m_rem = E_md_div ? 10 : 5;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        cycle_check();
        cycle_check();
        check_eq("reset_stall", {31'd0, last_stall}, 32'd0);
        reset = 1'b0;

        // Load-use against E.
        E_wa = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
        cycle_check();
        check_eq("loaduse_stall", {31'd0, last_stall}, 32'd1);
        D_tuse_rs = 2'd2;
        cycle_check();
        check_eq("loaduse_late_tuse", {31'd0, last_stall}, 32'd0);

        // Register zero never hazards; M producer does.
        idle_inputs();
        E_wa = 5'd0; E_tnew = 2'd2; D_rs = 5'd0; D_tuse_rs = 2'd0;
        cycle_check();
        check_eq("zero_reg", {31'd0, last_stall}, 32'd0);
        M_wa = 5'd5; M_tnew = 2'd1; D_rt = 5'd5; D_tuse_rt = 2'd0;
        cycle_check();
        check_eq("m_hazard_rt", {31'd0, last_stall}, 32'd1);

        // Mult issue with md instruction held in D: 6 stall cycles.
        idle_inputs();
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
        cnt = 0;
        cycle_check();
        if (last_stall) cnt++;
        E_md_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle_check();
            if (last_stall) cnt++;
        end
        check_eq("mult_stall_cycles", cnt, 32'd6);
        check_eq("mult_done", {31'd0, last_stall}, 32'd0);

        // Div issue without md in D: 11 busy cycles, no stall.
        idle_inputs();
        E_md_start = 1'b1; E_md_div = 1'b1;
        cnt = 0;
        cycle_check();
        if (last_busy) cnt++;
        E_md_start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            cycle_check();
            if (last_busy) cnt++;
            check_eq("div_no_stall", {31'd0, last_stall}, 32'd0);
        end
        check_eq("div_busy_cycles", cnt, 32'd11);

        // Overlapping issue at cnt=3: error, no reload.
        idle_inputs();
        E_md_start = 1'b1;
        cycle_check();
        E_md_start = 1'b0;
        cycle_check();
        cycle_check();
        E_md_start = 1'b1;
        cycle_check();
        E_md_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle_check();
            if (last_busy) cnt++;
        end
        check_eq("overlap_tail", cnt, 32'd2);
        check_eq("overlap_err", {31'd0, last_err}, 32'd1);

        // Reset while busy (cnt=7).
        idle_inputs();
        E_md_start = 1'b1; E_md_div = 1'b1;
        cycle_check();
        E_md_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle_check();
        D_is_md = 1'b1;
        reset = 1'b1;
        cycle_check();
        check_eq("rst_busy", {31'd0, last_busy}, 32'd0);
        check_eq("rst_stall", {31'd0, last_stall}, 32'd0);
        check_eq("rst_err", {31'd0, last_err}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle_check();
            if (last_busy || last_stall) cnt++;
        end
        check_eq("post_rst_idle", cnt, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 79) == 0);
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            D_tuse_rs  = 2'($urandom_range(0, 3));
            D_tuse_rt  = 2'($urandom_range(0, 3));
            D_is_md    = 1'($urandom_range(0, 1));
            E_wa       = 5'($urandom_range(0, 3));
            E_tnew     = 2'($urandom_range(0, 3));
            M_wa       = 5'($urandom_range(0, 3));
            M_tnew     = 2'($urandom_range(0, 3));
            E_md_start = ($urandom_range(0, 11) == 0);
            E_md_div   = 1'($urandom_range(0, 1));
            cycle_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
